// File: rtl/serializador.sv
// serializador: parallel-to-serial link transmitter, MSB first.
// Sends a COM alignment burst after reset and COM filler when idle.
module serializador #(
  parameter int              BITS        = 8,
  parameter logic [BITS-1:0] COM         = 8'hBC,
  parameter int              ALIGN_COUNT = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] in,
  input  logic            in_DK,
  input  logic            valid,
  output logic            ready,
  output logic            data,
  output logic            DK,
  output logic            sym_start,
  output logic            active
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int AW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
  localparam logic [CW-1:0] LAST_BIT   = CW'(BITS - 1);
  localparam logic [AW-1:0] LAST_ALIGN = AW'(ALIGN_COUNT - 1);

  typedef enum logic {
    ALIGN,
    RUN
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   align_cnt;
  logic [AW-1:0]   align_nx;
  logic [BITS-1:0] shreg;
  logic            dk_r;
  logic            act_r;
  logic [CW-1:0]   bit_cnt;
  logic            load;
  logic            take;

  assign load      = (bit_cnt == LAST_BIT);
  assign ready     = load &&
                     (state == RUN || align_cnt == LAST_ALIGN);
  assign take      = ready && valid;

  assign data      = shreg[BITS-1];
  assign DK        = dk_r;
  assign active    = act_r;
  assign sym_start = (bit_cnt == '0);

  // alignment FSM state and COM burst counter
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ALIGN;
      align_cnt <= '0;
    end else begin
      state     <= state_nx;
      align_cnt <= align_nx;
    end
  end

  // FSM advances only on symbol boundaries
  always_comb begin
    state_nx = state;
    align_nx = align_cnt;
    if (load) begin
      unique case (state)
        ALIGN: begin
          if (align_cnt == LAST_ALIGN)
            state_nx = RUN;
          else
            align_nx = align_cnt + AW'(1);
        end
        RUN: state_nx = RUN;
      endcase
    end
  end

  // shift out current symbol, load next one at the last bit
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      shreg   <= COM;
      dk_r    <= 1'b1;
      act_r   <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
      if (take) begin
        shreg <= in;
        dk_r  <= in_DK;
        act_r <= 1'b1;
      end else begin
        shreg <= COM;
        dk_r  <= 1'b1;
        act_r <= 1'b0;
      end
    end else begin
      shreg   <= {shreg[BITS-2:0], 1'b0};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serializador.sv
// tb_serializador: self-checking bench for serializador.
// Symbol-level reference model with a randomized source.
module tb_serializador;

  localparam int        BITS = 8;
  localparam logic [7:0] COM = 8'hBC;
  localparam int        AC   = 4;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] in = '0;
  logic       in_DK = 1'b0;
  logic       valid = 1'b0;
  logic       ready;
  logic       data;
  logic       DK;
  logic       sym_start;
  logic       active;

  serializador #(
    .BITS(BITS),
    .COM(COM),
    .ALIGN_COUNT(AC)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .in(in),
    .in_DK(in_DK),
    .valid(valid),
    .ready(ready),
    .data(data),
    .DK(DK),
    .sym_start(sym_start),
    .active(active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sym;
    logic       dk;
    logic       act;
  } sym_t;

  sym_t stream[$];
  sym_t src_q[$];
  sym_t sent_q[$];
  int   k;
  int   n_checks = 0;
  int   n_fail = 0;
  int   go_pct = 100;
  int   start_cyc = 0;
  bit   src_go;

  // link timing: first slot at cycle AC*BITS-1, then every BITS
  function automatic bit exp_ready(int c);
    return (c % BITS == BITS-1) && (c >= AC*BITS-1);
  endfunction

  function automatic logic exp_data(int c);
    sym_t e;
    e = stream[c/BITS];
    return e.sym[BITS-1 - c%BITS];
  endfunction

  function automatic logic exp_dk(int c);
    sym_t e;
    e = stream[c/BITS];
    return e.dk;
  endfunction

  function automatic logic exp_act(int c);
    sym_t e;
    e = stream[c/BITS];
    return e.act;
  endfunction

  task automatic reset_model();
    stream.delete();
    stream.push_back(sym_t'{COM, 1'b1, 1'b0});
    k = 0;
    src_go = 1'b0;
  endtask

  // source: may wait before offering, then holds until taken
  task automatic drive();
    if (!src_go && src_q.size() > 0 && k >= start_cyc &&
        $urandom_range(99) < go_pct)
      src_go = 1'b1;
    valid = src_go;
    if (src_go) begin
      in    = src_q[0].sym;
      in_DK = src_q[0].dk;
    end else begin
      in    = 8'($urandom);
      in_DK = 1'($urandom);
    end
  endtask

  task automatic tick();
    drive();
    if (k % BITS == BITS-1) begin
      if (exp_ready(k) && valid) begin
        stream.push_back(sym_t'{in, in_DK, 1'b1});
        void'(src_q.pop_front());
        src_go = 1'b0;
      end else begin
        stream.push_back(sym_t'{COM, 1'b1, 1'b0});
      end
    end
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    valid = 1'b0;
    src_q.delete();
    repeat (3) @(negedge clk);
    reset_L = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    repeat (3) begin
      valid = 1'($urandom);
      in = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (data !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_data got %b want 1", data);
      end
      n_checks++;
      if (DK !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_dk got %b want 1", DK);
      end
      n_checks++;
      if (sym_start !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_start got %b want 1", sym_start);
      end
      n_checks++;
      if (active !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_active got %b want 0", active);
      end
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ready got %b want 0", ready);
      end
    end
  endtask

  task automatic test_alignment();
    int first;
    logic [7:0] pat;
    pat = COM;
    first = -1;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      if (ready === 1'b1 && first < 0) first = k;
      if (k < AC*BITS) begin
        n_checks++;
        if (data !== pat[7 - k%8] || DK !== 1'b1) begin
          n_fail++;
          $display("FAIL align_com k=%0d got %b/%b want %b/1",
                   k, data, DK, pat[7 - k%8]);
        end
      end
      n_checks++;
      if (ready !== exp_ready(k) ||
          sym_start !== (k % BITS == 0) ||
          active !== 1'b0) begin
        n_fail++;
        $display("FAIL align_ctl k=%0d got r%b s%b a%b", k,
                 ready, sym_start, active);
      end
      tick();
    end
    n_checks++;
    if (first != AC*BITS-1) begin
      n_fail++;
      $display("FAIL align_first_ready got %0d want %0d",
               first, AC*BITS-1);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    src_q.push_back(sym_t'{8'hA5, 1'b0, 1'b0});
    start_cyc = 20;
    go_pct = 100;
    for (int c = 0; c < 48; c++) begin
      n_checks++;
      if (data !== exp_data(k) || DK !== exp_dk(k) ||
          active !== exp_act(k) || ready !== exp_ready(k)) begin
        n_fail++;
        $display("FAIL single k=%0d got d%b k%b a%b r%b want d%b k%b a%b r%b",
                 k, data, DK, active, ready, exp_data(k),
                 exp_dk(k), exp_act(k), exp_ready(k));
      end
      if (k == 35) begin
        n_checks++;
        if (active !== 1'b1 || DK !== 1'b0) begin
          n_fail++;
          $display("FAIL single_user got a%b k%b want a1 k0",
                   active, DK);
        end
      end
      if (k == 40) begin
        n_checks++;
        if (active !== 1'b0 || data !== 1'b1 || DK !== 1'b1) begin
          n_fail++;
          $display("FAIL single_back_to_com got a%b d%b k%b", active,
                   data, DK);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    src_q.push_back(sym_t'{8'h3C, 1'b0, 1'b0});
    src_q.push_back(sym_t'{8'h1C, 1'b1, 1'b0});
    src_q.push_back(sym_t'{8'hFF, 1'b0, 1'b0});
    src_q.push_back(sym_t'{COM,   1'b1, 1'b0});
    start_cyc = 0;
    go_pct = 100;
    for (int c = 0; c < 80; c++) begin
      n_checks++;
      if (data !== exp_data(k) || DK !== exp_dk(k) ||
          active !== exp_act(k) || ready !== exp_ready(k) ||
          sym_start !== (k % BITS == 0)) begin
        n_fail++;
        $display("FAIL b2b k=%0d got d%b k%b a%b r%b want d%b k%b a%b r%b",
                 k, data, DK, active, ready, exp_data(k),
                 exp_dk(k), exp_act(k), exp_ready(k));
      end
      if (k >= 32 && k < 64) begin
        n_checks++;
        if (active !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_bubble k=%0d got a%b want a1", k, active);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    do_reset();
    src_q.push_back(sym_t'{8'hA5, 1'b0, 1'b0});
    start_cyc = 0;
    go_pct = 100;
    while (k < 35) tick();
    #2 reset_L = 1'b0;
    #1;
    n_checks++;
    if (data !== 1'b1 || DK !== 1'b1 || sym_start !== 1'b1 ||
        active !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async got d%b k%b s%b a%b r%b", data, DK,
               sym_start, active, ready);
    end
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    reset_model();
    src_q.push_back(sym_t'{8'h5A, 1'b0, 1'b0});
    for (int c = 0; c < 48; c++) begin
      if (ready === 1'b1 && first < 0) first = k;
      n_checks++;
      if (data !== exp_data(k) || DK !== exp_dk(k) ||
          active !== exp_act(k) || ready !== exp_ready(k)) begin
        n_fail++;
        $display("FAIL midrst k=%0d got d%b k%b a%b r%b want d%b k%b a%b r%b",
                 k, data, DK, active, ready, exp_data(k),
                 exp_dk(k), exp_act(k), exp_ready(k));
      end
      tick();
    end
    n_checks++;
    if (first != AC*BITS-1) begin
      n_fail++;
      $display("FAIL midrst_first_ready got %0d want %0d", first,
               AC*BITS-1);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] rx;
    sym_t       s;
    sym_t       e;
    int         got;
    rx = '0;
    got = 0;
    do_reset();
    sent_q.delete();
    for (int i = 0; i < 10; i++) begin
      s = sym_t'{8'($urandom), 1'($urandom), 1'b0};
      if (i == 5) s = sym_t'{COM, 1'b1, 1'b0};
      src_q.push_back(s);
      sent_q.push_back(s);
    end
    start_cyc = 0;
    go_pct = 40;
    for (int c = 0; c < 800 && sent_q.size() > 0; c++) begin
      rx = {rx[6:0], data};
      if (k % BITS == BITS-1 && active === 1'b1) begin
        e = sent_q.pop_front();
        got++;
        n_checks++;
        if (rx !== e.sym || DK !== e.dk) begin
          n_fail++;
          $display("FAIL loopback #%0d got %h/%b want %h/%b", got, rx,
                   DK, e.sym, e.dk);
        end
      end
      n_checks++;
      if (data !== exp_data(k) || active !== exp_act(k) ||
          ready !== exp_ready(k)) begin
        n_fail++;
        $display("FAIL loop_model k=%0d got d%b a%b r%b want d%b a%b r%b",
                 k, data, active, ready, exp_data(k), exp_act(k),
                 exp_ready(k));
      end
      tick();
    end
    n_checks++;
    if (sent_q.size() != 0) begin
      n_fail++;
      $display("FAIL loopback_timeout got %0d left want 0",
               sent_q.size());
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_alignment();
    test_single_word();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
